// File: rtl/fft_frame_ctrl_if.sv
// Sample-stream and FFT-block bus of the FFT frame sequencer.
// master = sample source / FFT side, slave = fft_frame_ctrl.
interface fft_frame_ctrl_if #(
    parameter int WIDTH_INPUT = 9,
    parameter int BLOCK_LEN   = 16
);
    logic                                 s_valid;
    logic                                 s_ready;
    logic signed [WIDTH_INPUT-1:0]        s_i;
    logic signed [WIDTH_INPUT-1:0]        s_q;
    logic                                 s_last;
    logic                                 fft_valid;
    logic [BLOCK_LEN*WIDTH_INPUT-1:0]     fft_din_i;
    logic [BLOCK_LEN*WIDTH_INPUT-1:0]     fft_din_q;
    logic                                 fft_do_en;

    modport master (
        output s_valid, s_i, s_q, s_last, fft_do_en,
        input  s_ready, fft_valid, fft_din_i, fft_din_q
    );

    modport slave (
        input  s_valid, s_i, s_q, s_last, fft_do_en,
        output s_ready, fft_valid, fft_din_i, fft_din_q
    );
endinterface

// File: rtl/fft_frame_ctrl.sv
// Input sequencer for the FFT: packs serial samples into parallel blocks, stalls per frame
// until the FFT output strobe, counts frames, watchdogs latency. Optional FFT_FRAME_PAD_EN.
module fft_frame_ctrl #(
    parameter int TOTAL_SIZE  = 512,
    parameter int BLOCK_LEN   = 16,
    parameter int WIDTH_INPUT = 9,
    parameter int MAX_LAT     = 64,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    fft_frame_ctrl_if.slave   bus,
    output logic              busy,
    output logic              frame_done,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              err_timeout
);
    localparam int NBLK   = TOTAL_SIZE / BLOCK_LEN;
    localparam int SLOT_W = $clog2(BLOCK_LEN);
    localparam int BLK_W  = $clog2(NBLK);
    localparam int WD_W   = $clog2(MAX_LAT + 1);
    localparam int VEC_W  = BLOCK_LEN * WIDTH_INPUT;

    typedef enum logic [1:0] {IDLE, FILL, WAIT_OUT, PAD} state_t;

    state_t             state, state_nxt;
    logic [SLOT_W-1:0]  slot;
    logic [BLK_W-1:0]   blk;
    logic [WD_W-1:0]    wdog;
    logic [VEC_W-1:0]   stage_i, stage_q;
    logic [VEC_W-1:0]   block_i, block_q;
    logic               accept, block_end, last_blk, pad_start, issue, to_wait, wd_expire;

    assign bus.s_ready = (state == IDLE) || (state == FILL);
    assign busy        = (state != IDLE);

    assign accept    = bus.s_valid && bus.s_ready;
    assign block_end = accept && (slot == SLOT_W'(BLOCK_LEN - 1));
    assign last_blk  = (blk == BLK_W'(NBLK - 1));
    assign wd_expire = (wdog == WD_W'(MAX_LAT - 1));

`ifdef FFT_FRAME_PAD_EN
    // s_last on the final sample of a full frame is just a normal frame end.
    assign pad_start = accept && bus.s_last && !(block_end && last_blk);
`else
    logic unused_s_last;
    assign unused_s_last = bus.s_last;
    assign pad_start     = 1'b0;
`endif

    assign issue   = block_end || pad_start;
    assign to_wait = issue && last_blk;

    // Outgoing block = staging register with the current sample merged into its slot.
    always_comb begin
        block_i = stage_i;
        block_q = stage_q;
        block_i[slot*WIDTH_INPUT +: WIDTH_INPUT] = bus.s_i;
        block_q[slot*WIDTH_INPUT +: WIDTH_INPUT] = bus.s_q;
`ifdef FFT_FRAME_PAD_EN
        for (int j = 0; j < BLOCK_LEN; j++) begin
            if (j > int'(slot)) begin
                block_i[j*WIDTH_INPUT +: WIDTH_INPUT] = '0;
                block_q[j*WIDTH_INPUT +: WIDTH_INPUT] = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: state_nxt gets its default before the case, so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, FILL: begin
                if (to_wait)        state_nxt = WAIT_OUT;
                else if (pad_start) state_nxt = PAD;
                else if (accept)    state_nxt = FILL;
            end
            PAD:      if (last_blk) state_nxt = WAIT_OUT;
            WAIT_OUT: if (bus.fft_do_en || wd_expire) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // NOTE: the staging register has no reset: every slot is written (or masked) before it is issued.
    always_ff @(posedge clk) begin
        if (accept) begin
            stage_i[slot*WIDTH_INPUT +: WIDTH_INPUT] <= bus.s_i;
            stage_q[slot*WIDTH_INPUT +: WIDTH_INPUT] <= bus.s_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot          <= '0;
            blk           <= '0;
            wdog          <= '0;
            bus.fft_valid <= 1'b0;
            bus.fft_din_i <= '0;
            bus.fft_din_q <= '0;
            frame_done    <= 1'b0;
            frame_cnt     <= '0;
            err_timeout   <= 1'b0;
        end else begin
            bus.fft_valid <= 1'b0;
            frame_done    <= 1'b0;

            if (accept) slot <= issue ? '0 : slot + 1'b1;

            if (issue) begin
                bus.fft_din_i <= block_i;
                bus.fft_din_q <= block_q;
                bus.fft_valid <= 1'b1;
                blk           <= last_blk ? '0 : blk + 1'b1;
            end else if (state == PAD) begin
                bus.fft_din_i <= '0;
                bus.fft_din_q <= '0;
                bus.fft_valid <= 1'b1;
                blk           <= last_blk ? '0 : blk + 1'b1;
            end

            // fft_do_en takes priority over a watchdog expiry in the same cycle.
            if (state == WAIT_OUT) begin
                if (bus.fft_do_en) begin
                    frame_done <= 1'b1;
                    frame_cnt  <= frame_cnt + 1'b1;
                end else if (wd_expire) begin
                    err_timeout <= 1'b1;
                end
                wdog <= (bus.fft_do_en || wd_expire) ? '0 : wdog + 1'b1;
            end else begin
                wdog <= '0;
            end
        end
    end
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboard bench for fft_frame_ctrl: stimulus pushes expected blocks / frame_done cycles,
// a negedge monitor pops and compares whenever the DUT strobes.
module tb_fft_frame_ctrl;
    localparam int W       = 9;
    localparam int B       = 16;
    localparam int NBLK    = 32;
    localparam int MAX_LAT = 64;
    localparam int CNT_W   = 16;
`ifdef FFT_FRAME_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    typedef struct {
        logic [W*B-1:0] i;
        logic [W*B-1:0] q;
        int             cyc;
    } blk_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             busy, frame_done, err_timeout;
    logic [CNT_W-1:0] frame_cnt;
    int               cyc = 0;
    int               n_checks = 0;
    int               n_fail = 0;
    int               exp_cnt = 0;

    blk_t             exp_q[$];
    int               fd_q[$];
    logic [W-1:0]     m_i[B];
    logic [W-1:0]     m_q[B];
    int               m_slot = 0;
    int               m_blk = 0;

    fft_frame_ctrl_if #(.WIDTH_INPUT(W), .BLOCK_LEN(B)) bus ();

    fft_frame_ctrl #(
        .TOTAL_SIZE(512), .BLOCK_LEN(B), .WIDTH_INPUT(W), .MAX_LAT(MAX_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_slot = 0;
        m_blk  = 0;
    endtask

    task automatic model_accept(input logic [W-1:0] si, input logic [W-1:0] sq, input bit last, input int hs);
        m_i[m_slot] = si;
        m_q[m_slot] = sq;
        m_slot++;
        if (m_slot == B || (PAD_EN && last)) begin
            blk_t e;
            e.i = '0;
            e.q = '0;
            for (int j = 0; j < m_slot; j++) begin
                e.i[j*W +: W] = m_i[j];
                e.q[j*W +: W] = m_q[j];
            end
            e.cyc = hs;
            exp_q.push_back(e);
            if (PAD_EN && last) begin
                for (int b = m_blk + 1; b < NBLK; b++) begin
                    e.i   = '0;
                    e.q   = '0;
                    e.cyc = hs + (b - m_blk);
                    exp_q.push_back(e);
                end
                m_blk = 0;
            end else begin
                m_blk = (m_blk + 1) % NBLK;
            end
            m_slot = 0;
        end
    endtask

    // Sample k carries s_i = k mod 256, s_q = -(k mod 256).
    task automatic send_range(input int k0, input int k1, input bit gap, input int do_en_at, input int last_at);
        for (int k = k0; k < k1; k++) begin
            int n = 0;
            if (gap) begin
                bus.s_valid = 1'b0;
                tick();
            end
            bus.s_valid   = 1'b1;
            bus.s_i       = W'(k % 256);
            bus.s_q       = W'(-(k % 256));
            bus.s_last    = (k == last_at);
            bus.fft_do_en = (k == do_en_at);
            while (!bus.s_ready && n < 200) begin
                tick();
                n++;
            end
            if (!bus.s_ready) begin
                check("s_ready_wait", bus.s_ready, 1'b1);
                break;
            end
            tick();
            model_accept(W'(k % 256), W'(-(k % 256)), k == last_at, cyc);
        end
        bus.s_valid   = 1'b0;
        bus.s_last    = 1'b0;
        bus.fft_do_en = 1'b0;
    endtask

    task automatic complete_frame(input int delay);
        repeat (delay) tick();
        bus.fft_do_en = 1'b1;
        fd_q.push_back(cyc + 1);
        exp_cnt++;
        tick();
        bus.fft_do_en = 1'b0;
        check("frame_cnt_after_done", frame_cnt, exp_cnt);
        check("s_ready_after_done", bus.s_ready, 1'b1);
        check("busy_after_done", busy, 1'b0);
    endtask

    task automatic reset_check(input string tag);
        check({tag, "_s_ready"}, bus.s_ready, 1'b1);
        check({tag, "_fft_valid"}, bus.fft_valid, 1'b0);
        check({tag, "_din_i"}, bus.fft_din_i, '0);
        check({tag, "_din_q"}, bus.fft_din_q, '0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_frame_done"}, frame_done, 1'b0);
        check({tag, "_frame_cnt"}, frame_cnt, '0);
        check({tag, "_err"}, err_timeout, 1'b0);
    endtask

    // Monitor: compare every DUT strobe against the scoreboard queues.
    always @(negedge clk) begin
        if (bus.fft_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_fft_valid", bus.fft_valid, 1'b0);
            end else begin
                blk_t e;
                e = exp_q.pop_front();
                check("block_cycle", cyc, e.cyc);
                check("block_din_i", bus.fft_din_i, e.i);
                check("block_din_q", bus.fft_din_q, e.q);
            end
        end
        if (frame_done) begin
            if (fd_q.size() == 0) check("spurious_frame_done", frame_done, 1'b0);
            else                  check("frame_done_cycle", cyc, fd_q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish by %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [W*B-1:0] ramp_i, ramp_q;
        for (int j = 0; j < B; j++) begin
            ramp_i[j*W +: W] = W'(j);
            ramp_q[j*W +: W] = W'(-j);
        end

        rst = 1'b1;
        bus.s_valid = 1'b0; bus.s_i = '0; bus.s_q = '0; bus.s_last = 1'b0; bus.fft_do_en = 1'b0;
        repeat (3) tick();
        reset_check("reset");
        rst = 1'b0;
        model_reset();

        // Frame 1: continuous stream, block 0 checked directly against the ramp.
        send_range(0, 16, 1'b0, -1, -1);
        check("first_strobe", bus.fft_valid, 1'b1);
        check("block0_i_ramp", bus.fft_din_i, ramp_i);
        check("block0_q_ramp", bus.fft_din_q, ramp_q);
        send_range(16, 512, 1'b0, -1, -1);
        check("s_ready_after_511", bus.s_ready, 1'b0);
        check("busy_in_wait", busy, 1'b1);
        complete_frame(4);
        tick();
        check("frame_done_one_cycle", frame_done, 1'b0);

        // Frame 2
        send_range(0, 512, 1'b0, -1, -1);
        complete_frame(4);

        // Frame 3: no fft_do_en, watchdog fires MAX_LAT cycles into WAIT_OUT.
        send_range(0, 512, 1'b0, -1, -1);
        repeat (MAX_LAT - 1) tick();
        check("err_before_expiry", err_timeout, 1'b0);
        tick();
        check("err_at_expiry", err_timeout, 1'b1);
        check("busy_after_timeout", busy, 1'b0);
        check("cnt_after_timeout", frame_cnt, exp_cnt);
        send_range(0, 512, 1'b0, -1, -1);
        complete_frame(4);
        check("err_sticky", err_timeout, 1'b1);

        // Toggling s_valid, then reset mid-frame after 100 samples.
        send_range(0, 100, 1'b1, -1, -1);
        rst = 1'b1;
        tick();
        reset_check("midreset");
        rst = 1'b0;
        model_reset();
        exp_cnt = 0;
        send_range(0, 512, 1'b0, -1, -1);
        complete_frame(3);

        // fft_do_en in IDLE and during FILL is ignored; then on the exact expiry cycle.
        bus.fft_do_en = 1'b1;
        tick();
        bus.fft_do_en = 1'b0;
        check("cnt_do_en_idle", frame_cnt, exp_cnt);
        send_range(0, 512, 1'b0, 40, -1);
        check("cnt_do_en_fill", frame_cnt, exp_cnt);
        complete_frame(MAX_LAT - 1);
        check("err_do_en_wins", err_timeout, 1'b0);

        if (PAD_EN) begin
            send_range(0, 21, 1'b0, -1, 20);
            check("pad_s_ready_low", bus.s_ready, 1'b0);
            repeat (NBLK - 2) tick();
            check("pad_last_block", bus.fft_valid, 1'b1);
            tick();
            check("pad_no_more", bus.fft_valid, 1'b0);
            check("pad_busy_wait", busy, 1'b1);
            complete_frame(2);
        end

        repeat (3) tick();
        check("blocks_drained", exp_q.size(), 0);
        check("frame_done_drained", fd_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
- Input sequencer for the 512-point FFT datapath.
- Accepts a serial complex sample stream, one sample per handshake. Packs every 16 samples into the parallel block vector the FFT consumes and issues one data-valid pulse per block.
- After 32 blocks (one frame), stalls the stream until the FFT output strobe returns, then rearms for the next frame.
- Sits between the sample source and the FFT top; also provides frame counting and a latency watchdog.

Parameters:
- TOTAL_SIZE, 512: points per frame.
- BLOCK_LEN, 16: samples per parallel block. TOTAL_SIZE/BLOCK_LEN is a power of two.
- WIDTH_INPUT, 9: signed sample width, I and Q.
- MAX_LAT, 64: watchdog limit in cycles, counted from the last block issued to the FFT output strobe.
- CNT_W, 16: frame counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  input sample valid
- s_ready  out  1  controller can accept a sample
- s_i  in  WIDTH_INPUT  signed in-phase sample
- s_q  in  WIDTH_INPUT  signed quadrature sample
- s_last  in  1  last sample of a short frame (used only with the optional feature)
- fft_valid  out  1  one-cycle block strobe to the FFT data_valid input
- fft_din_i  out  WIDTH_INPUT x BLOCK_LEN  packed in-phase block, index 0 = first sample
- fft_din_q  out  WIDTH_INPUT x BLOCK_LEN  packed quadrature block
- fft_do_en  in  1  FFT output-valid strobe
- busy  out  1  frame in progress (not IDLE)
- frame_done  out  1  one-cycle pulse when a frame's FFT output arrives
- frame_cnt  out  CNT_W  completed frames, wraps modulo 2^CNT_W
- err_timeout  out  1  sticky watchdog error

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: s_ready=1, fft_valid=0, fft_din_i/q all 0, busy=0, frame_done=0, frame_cnt=0, err_timeout=0. State is IDLE and all counters are 0.
- Handshake: a sample is accepted when s_valid and s_ready are both 1 on a rising edge. s_ready is combinational from state: 1 in IDLE and FILL, 0 in WAIT_OUT.
- Packing: a sample-in-block counter (0..BLOCK_LEN-1) selects the slot in a staging register. The staging register is copied to fft_din_i/q on the 16th accepted sample. The outputs then hold stable until the next block is issued.
- Block issue: fft_valid=1 for exactly the cycle after the 16th handshake, alongside the new vector. This gives 1-cycle latency from the last sample to the strobe. Back-to-back blocks are allowed: with a continuous stream, fft_valid fires every 16 cycles.
- State IDLE: the first handshake stores sample 0 and moves to FILL. busy=1 from the next cycle.
- State FILL: keep accepting samples. Gaps in s_valid stall the counters, with no timeout. After the handshake that completes block TOTAL_SIZE/BLOCK_LEN-1 (the 32nd block), move to WAIT_OUT. The watchdog clears to 0 at that point.
- State WAIT_OUT:
  - The watchdog increments every cycle.
  - If fft_do_en=1: pulse frame_done for one cycle, increment frame_cnt, clear the watchdog, go to IDLE. s_ready is 1 again on the following cycle.
  - If the watchdog reaches MAX_LAT with no fft_do_en: set err_timeout (sticky, cleared only by rst), no frame_done, no frame_cnt increment, go to IDLE.
  - If fft_do_en arrives on the same cycle the watchdog reaches MAX_LAT, fft_do_en wins: normal completion, no error.
- fft_do_en in IDLE or FILL is ignored, with no counter effect.
- Reset mid-frame: rst overrides everything. The partial frame is discarded and all outputs return to reset values on the next edge.
- Data path: no arithmetic on samples. Widths pass through unchanged.

Optional Feature:
- Macro: FFT_FRAME_PAD_EN.
- With the macro defined:
  - An accepted sample with s_last=1 in FILL, or on the first handshake from IDLE, ends input early. s_ready drops to 0 from the next cycle.
  - The current block's remaining slots are zero-filled and issued.
  - Every remaining block of the frame is issued as all-zero, one fft_valid per cycle on consecutive cycles. Then go to WAIT_OUT.
  - s_last on the final sample of a full frame has no extra effect.
- Without the macro: s_last is ignored, with no pad logic.

Test Plan:
- Reset, then 512 continuous samples with s_i=k mod 256 and s_q=-(k mod 256) -> 32 fft_valid pulses spaced 16 cycles apart; the first comes 1 cycle after the 16th handshake; block 0 has fft_din_i[j]=j; s_ready=0 after sample 511.
- Complete the frame, then fft_do_en 5 cycles after the last block -> frame_done for one cycle, frame_cnt=1, s_ready=1 the next cycle, busy=0; repeat for a second frame -> frame_cnt=2.
- Full frame with no fft_do_en -> err_timeout=1 MAX_LAT cycles after entering WAIT_OUT, frame_cnt unchanged, state IDLE; a later normal frame completes and err_timeout stays 1.
- s_valid toggling 1/0 each cycle -> fft_valid every 32 cycles with correct packing; rst asserted after 100 samples -> all outputs at reset values next cycle; the next 512 samples form a clean frame with block 0 = samples 0..15.
- fft_do_en pulsed during FILL -> ignored; fft_do_en on the exact watchdog-expiry cycle -> frame_done=1 and err_timeout=0.
- With FFT_FRAME_PAD_EN: s_last on sample 20 -> block 1 holds samples 16..20 then zeros, followed by 30 all-zero blocks on consecutive cycles, then WAIT_OUT.
